// File: rtl/acc_seq_pkg.sv
// ---------------------------------------------------------------------------
// acc_seq_pkg
// Shared definitions for the FIR accumulator read sequencer:
//   state_t     - sequencer FSM states
//   INSEL_*     - accumulator input-select codes
//   NUM_TERMS   - partial products summed per output sample
//   SRAM_RD_LAT - single-port SRAM read latency in cycles
// ---------------------------------------------------------------------------
package acc_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] INSEL_FIRST = 4'd0;
    localparam logic [3:0] INSEL_LAST  = 4'd9;

    // Select code driven while no term is in flight. It shares the value of
    // INSEL_FIRST, which only reloads the running sum and never fires the
    // accumulator's output register.
    localparam logic [3:0] INSEL_IDLE  = 4'd0;

    localparam int NUM_TERMS   = 10;
    localparam int SRAM_RD_LAT = 1;

endpackage : acc_seq_pkg

// File: rtl/acc_seq_addr_gen.sv
// ---------------------------------------------------------------------------
// acc_seq_addr_gen
// Holds the captured base address and the running read index, and forms the
// SRAM read address as base + index with ADDR_W-bit modulo wrap.
//
// Ports:
//   iClk       rising-edge clock
//   iRsn       synchronous active-low reset
//   iAccept    a new sample was accepted: capture base, clear index
//   iAdvance   step the read index by one
//   iBaseAddr  requested address of term 0
//   oAddr      current SRAM read address
//   oIdx       current read index (0 = first term)
//   oBank      (ACC_SEQ_PINGPONG_EN only) SRAM half being read
//
// Build option ACC_SEQ_PINGPONG_EN: a bank bit flips on every acceptance and
// the MSB of the captured base is inverted when it is set, so successive
// samples alternate between the two halves of the SRAM.
// ---------------------------------------------------------------------------
module acc_seq_addr_gen #(
    parameter int ADDR_W = 6
) (
    input  logic              iClk,
    input  logic              iRsn,
    input  logic              iAccept,
    input  logic              iAdvance,
    input  logic [ADDR_W-1:0] iBaseAddr,
    output logic [ADDR_W-1:0] oAddr,
    output logic [3:0]        oIdx
`ifdef ACC_SEQ_PINGPONG_EN
    ,
    output logic              oBank
`endif
);
    import acc_seq_pkg::*;

    logic [ADDR_W-1:0] rBase;
    logic [3:0]        rIdx;
    logic [ADDR_W-1:0] wEffBase;

`ifdef ACC_SEQ_PINGPONG_EN
    logic rBank;
    logic rReadBank;

    // The bank in use for this sample flips the address MSB; rBank then
    // toggles so that the following sample lands in the other half.
    assign wEffBase = iBaseAddr ^ {rBank, {(ADDR_W-1){1'b0}}};

    // Bank bookkeeping: rReadBank remembers which half the running sample
    // reads, rBank holds the half the next sample will use.
    always_ff @(posedge iClk) begin
        if (!iRsn) begin
            rBank     <= 1'b0;
            rReadBank <= 1'b0;
        end else if (iAccept) begin
            rBank     <= ~rBank;
            rReadBank <= rBank;
        end
    end

    assign oBank = rReadBank;
`else
    assign wEffBase = iBaseAddr;
`endif

    // Base is frozen at acceptance; the index restarts at the first term and
    // is stepped by the controller while reads are being issued.
    always_ff @(posedge iClk) begin
        if (!iRsn) begin
            rBase <= '0;
            rIdx  <= INSEL_FIRST;
        end else if (iAccept) begin
            rBase <= wEffBase;
            rIdx  <= INSEL_FIRST;
        end else if (iAdvance) begin
            rIdx  <= rIdx + 4'd1;
        end
    end

    // The sum is kept at ADDR_W bits so reads past the top of the SRAM wrap
    // to address 0 instead of leaving the array.
    assign oAddr = rBase + ADDR_W'(rIdx);
    assign oIdx  = rIdx;

endmodule : acc_seq_addr_gen

// File: rtl/acc_seq_ctrl.sv
// ---------------------------------------------------------------------------
// acc_seq_ctrl
// Sequencer for the FIR accumulator datapath. Each accepted sample request
// issues NUM_TERMS consecutive single-port SRAM reads, steers the
// accumulator input select so every returning word is summed, and flags the
// cycle in which the saturated filter output register holds the new result.
//
// Ports:
//   iClk       rising-edge clock
//   iRsn       synchronous active-low reset
//   iEnSample  one-cycle request for one output sample
//   iBaseAddr  SRAM address of term 0, sampled at acceptance
//   iOvfClr    clears oOvf
//   oCsn       SRAM chip select, active-low
//   oWrn       SRAM write enable, active-low, tied high (read only)
//   oAddr      SRAM read address
//   oInSel     accumulator input select (0 first term .. 9 last term)
//   oOutValid  accumulator output register holds a new result
//   oBusy      sequence in progress
//   oOvf       sticky: a sample request arrived while busy and was dropped
//   oBank      (ACC_SEQ_PINGPONG_EN only) SRAM half being read
//
// Build option ACC_SEQ_PINGPONG_EN enables alternate-half reading, see
// acc_seq_addr_gen.
//
// NUM_TERMS is tied to the accumulator's select encoding; only 10 is legal.
// ---------------------------------------------------------------------------
module acc_seq_ctrl #(
    parameter int ADDR_W    = 6,
    parameter int NUM_TERMS = 10
) (
    input  logic              iClk,
    input  logic              iRsn,
    input  logic              iEnSample,
    input  logic [ADDR_W-1:0] iBaseAddr,
    input  logic              iOvfClr,
    output logic              oCsn,
    output logic              oWrn,
    output logic [ADDR_W-1:0] oAddr,
    output logic [3:0]        oInSel,
    output logic              oOutValid,
    output logic              oBusy,
    output logic              oOvf
`ifdef ACC_SEQ_PINGPONG_EN
    ,
    output logic              oBank
`endif
);
    import acc_seq_pkg::*;

    localparam logic [3:0] LAST_IDX = 4'(NUM_TERMS - 1);

    state_t     rState;
    state_t     wNextState;
    logic [3:0] wIdx;
    logic [3:0] rInSel;
    logic       rOvf;
    logic       wAccept;
    logic       wAdvance;
    logic       wDrop;

    assign wAccept  = (rState == IDLE) && iEnSample;
    assign wDrop    = (rState != IDLE) && iEnSample;
    assign wAdvance = (rState == READ) && (wIdx != LAST_IDX);

    acc_seq_addr_gen #(
        .ADDR_W    (ADDR_W)
    ) uAddrGen (
        .iClk      (iClk),
        .iRsn      (iRsn),
        .iAccept   (wAccept),
        .iAdvance  (wAdvance),
        .iBaseAddr (iBaseAddr),
        .oAddr     (oAddr),
        .oIdx      (wIdx)
`ifdef ACC_SEQ_PINGPONG_EN
        ,
        .oBank     (oBank)
`endif
    );

    // State register.
    always_ff @(posedge iClk) begin
        if (!iRsn) begin
            rState <= IDLE;
        end else begin
            rState <= wNextState;
        end
    end

    // Next-state and Moore outputs. Outputs depend on the state register
    // only, so no input reaches an output combinationally. DRAIN covers the
    // SRAM latency of the last read; DONE is the cycle after the accumulator
    // output register was loaded.
    always_comb begin
        wNextState = rState;
        oCsn       = 1'b1;
        oOutValid  = 1'b0;
        oBusy      = 1'b1;
        case (rState)
            IDLE: begin
                oBusy = 1'b0;
                if (iEnSample) begin
                    wNextState = READ;
                end
            end
            READ: begin
                oCsn = 1'b0;
                if (wIdx == LAST_IDX) begin
                    wNextState = DRAIN;
                end
            end
            DRAIN: begin
                wNextState = DONE;
            end
            DONE: begin
                oOutValid  = 1'b1;
                wNextState = IDLE;
            end
            default: begin
                wNextState = IDLE;
            end
        endcase
    end

    // Input select trails the read index by the SRAM read latency so each
    // code lines up with the word it names; outside READ nothing is in
    // flight next cycle, so the idle code is loaded.
    always_ff @(posedge iClk) begin
        if (!iRsn) begin
            rInSel <= INSEL_IDLE;
        end else if (rState == READ) begin
            rInSel <= wIdx;
        end else begin
            rInSel <= INSEL_IDLE;
        end
    end

    // Sticky drop flag. A drop in the same cycle as a clear wins so that no
    // lost request can go unreported.
    always_ff @(posedge iClk) begin
        if (!iRsn) begin
            rOvf <= 1'b0;
        end else if (wDrop) begin
            rOvf <= 1'b1;
        end else if (iOvfClr) begin
            rOvf <= 1'b0;
        end
    end

    assign oInSel = rInSel;
    assign oOvf   = rOvf;
    assign oWrn   = 1'b1;

endmodule : acc_seq_ctrl

// File: tb/tb_acc_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_acc_seq_ctrl
// Directed bench for acc_seq_ctrl. A behavioural SRAM (1-cycle read) and a
// saturating 16-bit accumulator hang off the DUT outputs so the summed
// result can be checked against hand-computed values. SRAM word i holds
// (i mod 32) + 1, making both halves identical so the ping-pong build
// (ACC_SEQ_PINGPONG_EN) produces the same sums.
// ---------------------------------------------------------------------------
module tb_acc_seq_ctrl;
    localparam int ADDR_W = 6;

    logic              iClk = 1'b0;
    logic              iRsn;
    logic              iEnSample;
    logic [ADDR_W-1:0] iBaseAddr;
    logic              iOvfClr;
    logic              oCsn;
    logic              oWrn;
    logic [ADDR_W-1:0] oAddr;
    logic [3:0]        oInSel;
    logic              oOutValid;
    logic              oBusy;
    logic              oOvf;
`ifdef ACC_SEQ_PINGPONG_EN
    logic              oBank;
    logic              expBank;
    logic              seqBank;
    logic              capBank [1:13];
`endif

    int testsRun    = 0;
    int testsFailed = 0;

    acc_seq_ctrl #(
        .ADDR_W    (ADDR_W),
        .NUM_TERMS (10)
    ) dut (
        .iClk      (iClk),
        .iRsn      (iRsn),
        .iEnSample (iEnSample),
        .iBaseAddr (iBaseAddr),
        .iOvfClr   (iOvfClr),
        .oCsn      (oCsn),
        .oWrn      (oWrn),
        .oAddr     (oAddr),
        .oInSel    (oInSel),
        .oOutValid (oOutValid),
        .oBusy     (oBusy),
        .oOvf      (oOvf)
`ifdef ACC_SEQ_PINGPONG_EN
        ,
        .oBank     (oBank)
`endif
    );

    always #5 iClk = ~iClk;

    // SRAM and accumulator models driven by the DUT's control outputs.
    logic [15:0]        sram [0:63];
    logic [15:0]        rdData = 16'd0;
    logic signed [19:0] accSum = 20'sd0;
    logic [15:0]        accOut = 16'd0;
    logic signed [19:0] wTerm;
    logic signed [19:0] wSum;

    function automatic logic [15:0] sat16(input logic signed [19:0] v);
        if (v > 20'sd32767)       return 16'h7FFF;
        else if (v < -20'sd32768) return 16'h8000;
        else                      return v[15:0];
    endfunction

    always_comb begin
        wTerm = {{4{rdData[15]}}, rdData};
        wSum  = accSum + wTerm;
    end

    always @(posedge iClk) begin
        if (!oCsn && oWrn) rdData <= sram[oAddr];
        if (oInSel == 4'd0) accSum <= wTerm;
        else                accSum <= wSum;
        if (oInSel == 4'd9) accOut <= sat16(wSum);
    end

    // Per-cycle record of one sequence, index = cycles after acceptance.
    logic              capCsn   [1:13];
    logic [ADDR_W-1:0] capAddr  [1:13];
    logic [3:0]        capInSel [1:13];
    logic              capValid [1:13];
    logic              capBusy  [1:13];
    logic              capWrn   [1:13];
    logic [15:0]       capAcc   [1:13];
    logic [ADDR_W-1:0] seqBase;

    task automatic fill_sram();
        for (int i = 0; i < 64; i++) sram[i] = 16'((i % 32) + 1);
    endtask

    task automatic track_accept(input logic [ADDR_W-1:0] base);
`ifdef ACC_SEQ_PINGPONG_EN
        seqBase = expBank ? (base ^ 6'h20) : base;
        seqBank = expBank;
        expBank = ~expBank;
`else
        seqBase = base;
`endif
    endtask

    // Called just after a negedge of an idle cycle (t0); returns at the
    // negedge of t13 having recorded t1..t13.
    task automatic capture_sequence(input logic [ADDR_W-1:0] base);
        iBaseAddr = base;
        iEnSample = 1'b1;
        track_accept(base);
        for (int c = 1; c <= 13; c++) begin
            @(negedge iClk);
            iEnSample   = 1'b0;
            capCsn[c]   = oCsn;
            capAddr[c]  = oAddr;
            capInSel[c] = oInSel;
            capValid[c] = oOutValid;
            capBusy[c]  = oBusy;
            capWrn[c]   = oWrn;
            capAcc[c]   = accOut;
`ifdef ACC_SEQ_PINGPONG_EN
            capBank[c]  = oBank;
`endif
        end
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        iRsn = 1'b0; iEnSample = 1'b0; iOvfClr = 1'b0; iBaseAddr = 6'h15;
        repeat (2) @(negedge iClk);
        testsRun++;
        if ({oCsn, oWrn, oAddr, oInSel, oOutValid, oBusy, oOvf} !== {1'b1, 1'b1, 6'h00, 4'h0, 1'b0, 1'b0, 1'b0}) begin
            testsFailed++;
            $display("[TB] FAIL reset_values: got csn=%b wrn=%b addr=%h sel=%h valid=%b busy=%b ovf=%b, need 1 1 00 0 0 0 0",
                     oCsn, oWrn, oAddr, oInSel, oOutValid, oBusy, oOvf);
        end
        iRsn = 1'b1;
`ifdef ACC_SEQ_PINGPONG_EN
        expBank = 1'b0;
`endif
        @(negedge iClk);
    endtask

    task automatic test_basic();
        logic [3:0] expSel;
        $display("[TB] test_basic: base 0x00, terms 1..10");
        capture_sequence(6'h00);
        for (int c = 1; c <= 13; c++) begin
            testsRun++;
            if (capCsn[c] !== ((c <= 10) ? 1'b0 : 1'b1)) begin
                testsFailed++;
                $display("[TB] FAIL basic_csn t%0d: got %b", c, capCsn[c]);
            end
            if (c <= 10) begin
                testsRun++;
                if (capAddr[c] !== (seqBase + 6'(c - 1))) begin
                    testsFailed++;
                    $display("[TB] FAIL basic_addr t%0d: got %h need %h", c, capAddr[c], seqBase + 6'(c - 1));
                end
            end
            expSel = (c >= 2 && c <= 11) ? 4'(c - 2) : 4'd0;
            testsRun++;
            if (capInSel[c] !== expSel) begin
                testsFailed++;
                $display("[TB] FAIL basic_insel t%0d: got %0d need %0d", c, capInSel[c], expSel);
            end
            testsRun++;
            if (capValid[c] !== (c == 12)) begin
                testsFailed++;
                $display("[TB] FAIL basic_valid t%0d: got %b need %b", c, capValid[c], c == 12);
            end
            testsRun++;
            if (capBusy[c] !== (c <= 12)) begin
                testsFailed++;
                $display("[TB] FAIL basic_busy t%0d: got %b need %b", c, capBusy[c], c <= 12);
            end
            testsRun++;
            if (capWrn[c] !== 1'b1) begin
                testsFailed++;
                $display("[TB] FAIL basic_wrn t%0d: got %b need 1", c, capWrn[c]);
            end
        end
        testsRun++;
        if (capAcc[12] !== 16'd55) begin
            testsFailed++;
            $display("[TB] FAIL basic_sum: got %0d need 55", capAcc[12]);
        end
    endtask

    task automatic test_wrap();
        logic [ADDR_W-1:0] tab [0:9];
        logic [ADDR_W-1:0] expAddr;
        $display("[TB] test_wrap: base 0x3C");
        tab = '{6'h3C, 6'h3D, 6'h3E, 6'h3F, 6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05};
        capture_sequence(6'h3C);
        for (int k = 0; k < 10; k++) begin
            expAddr = tab[k] ^ (seqBase ^ 6'h3C);
            testsRun++;
            if (capAddr[k + 1] !== expAddr) begin
                testsFailed++;
                $display("[TB] FAIL wrap_addr term%0d: got %h need %h", k, capAddr[k + 1], expAddr);
            end
        end
        testsRun++;
        if (capAcc[12] !== 16'd143 || capValid[12] !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL wrap_sum: got %0d valid=%b need 143 valid=1", capAcc[12], capValid[12]);
        end
    endtask

    task automatic test_drop();
        $display("[TB] test_drop: request during sequence, clear, clear with drop");
        iBaseAddr = 6'h00;
        iEnSample = 1'b1;
        track_accept(6'h00);
        for (int c = 1; c <= 13; c++) begin
            @(negedge iClk);
            iEnSample = (c == 5);
            if (c == 5) begin
                testsRun++;
                if (oOvf !== 1'b0) begin
                    testsFailed++;
                    $display("[TB] FAIL drop_ovf_before: got %b need 0", oOvf);
                end
            end
            if (c == 6) begin
                testsRun++;
                if (oOvf !== 1'b1 || oInSel !== 4'd4 || oBusy !== 1'b1) begin
                    testsFailed++;
                    $display("[TB] FAIL drop_ovf_set: got ovf=%b sel=%0d busy=%b need 1 4 1", oOvf, oInSel, oBusy);
                end
            end
            if (c == 12) begin
                testsRun++;
                if (oOutValid !== 1'b1 || accOut !== 16'd55) begin
                    testsFailed++;
                    $display("[TB] FAIL drop_seq_intact: got valid=%b sum=%0d need 1 55", oOutValid, accOut);
                end
            end
        end
        iOvfClr = 1'b1;
        @(negedge iClk);
        iOvfClr = 1'b0;
        testsRun++;
        if (oOvf !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL drop_clear: got %b need 0", oOvf);
        end
        iEnSample = 1'b1;
        track_accept(6'h00);
        for (int c = 1; c <= 13; c++) begin
            @(negedge iClk);
            iEnSample = (c == 3) || (c == 5);
            iOvfClr   = (c == 5) || (c == 6);
            if (c == 4 || c == 6) begin
                testsRun++;
                if (oOvf !== 1'b1) begin
                    testsFailed++;
                    $display("[TB] FAIL drop_set_wins t%0d: got %b need 1", c, oOvf);
                end
            end
            if (c == 7) begin
                testsRun++;
                if (oOvf !== 1'b0) begin
                    testsFailed++;
                    $display("[TB] FAIL drop_clear2: got %b need 0", oOvf);
                end
            end
        end
        iOvfClr = 1'b0;
    endtask

    task automatic test_saturation();
        $display("[TB] test_saturation");
        for (int i = 0; i < 10; i++) begin sram[i] = 16'h7000; sram[i + 32] = 16'h7000; end
        capture_sequence(6'h00);
        testsRun++;
        if (capAcc[12] !== 16'h7FFF || capValid[12] !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL sat_pos: got %h valid=%b need 7fff valid=1", capAcc[12], capValid[12]);
        end
        for (int i = 0; i < 10; i++) begin sram[i] = 16'h9000; sram[i + 32] = 16'h9000; end
        capture_sequence(6'h00);
        testsRun++;
        if (capAcc[12] !== 16'h8000 || capValid[12] !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL sat_neg: got %h valid=%b need 8000 valid=1", capAcc[12], capValid[12]);
        end
        fill_sram();
    endtask

    task automatic test_back_to_back();
        $display("[TB] test_back_to_back: second request at t13");
        capture_sequence(6'h00);
        testsRun++;
        if (capAcc[12] !== 16'd55 || capValid[12] !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL b2b_first: got %0d valid=%b need 55 valid=1", capAcc[12], capValid[12]);
        end
        capture_sequence(6'h10);
        testsRun++;
        if (capBusy[1] !== 1'b1 || capCsn[1] !== 1'b0 || capAddr[1] !== seqBase) begin
            testsFailed++;
            $display("[TB] FAIL b2b_accept: got busy=%b csn=%b addr=%h need 1 0 %h", capBusy[1], capCsn[1], capAddr[1], seqBase);
        end
        testsRun++;
        if (capAcc[12] !== 16'd215 || capValid[12] !== 1'b1 || oOvf !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL b2b_second: got %0d valid=%b ovf=%b need 215 1 0", capAcc[12], capValid[12], oOvf);
        end
    endtask

    task automatic test_reset_mid();
        $display("[TB] test_reset_mid: reset at t6, restart at t8");
        iBaseAddr = 6'h08;
        iEnSample = 1'b1;
        track_accept(6'h08);
        for (int c = 1; c <= 8; c++) begin
            @(negedge iClk);
            iEnSample = (c == 2);
            testsRun++;
            if (oOutValid !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL rmid_no_valid t%0d: got %b need 0", c, oOutValid);
            end
            if (c == 3) begin
                testsRun++;
                if (oOvf !== 1'b1) begin
                    testsFailed++;
                    $display("[TB] FAIL rmid_ovf_pre: got %b need 1", oOvf);
                end
            end
            if (c == 6) begin
                testsRun++;
                if (oCsn !== 1'b0 || oBusy !== 1'b1) begin
                    testsFailed++;
                    $display("[TB] FAIL rmid_running: got csn=%b busy=%b need 0 1", oCsn, oBusy);
                end
                iRsn = 1'b0;
            end
            if (c == 7) begin
                iRsn = 1'b1;
`ifdef ACC_SEQ_PINGPONG_EN
                expBank = 1'b0;
`endif
                testsRun++;
                if ({oCsn, oWrn, oAddr, oInSel, oOutValid, oBusy, oOvf} !== {1'b1, 1'b1, 6'h00, 4'h0, 1'b0, 1'b0, 1'b0}) begin
                    testsFailed++;
                    $display("[TB] FAIL rmid_reset_values: got csn=%b wrn=%b addr=%h sel=%h valid=%b busy=%b ovf=%b, need 1 1 00 0 0 0 0",
                             oCsn, oWrn, oAddr, oInSel, oOutValid, oBusy, oOvf);
                end
            end
        end
        capture_sequence(6'h10);
        for (int c = 1; c <= 13; c++) begin
            testsRun++;
            if (capValid[c] !== (c == 12)) begin
                testsFailed++;
                $display("[TB] FAIL rmid_valid t%0d: got %b need %b", c, capValid[c], c == 12);
            end
        end
        testsRun++;
        if (capAddr[1] !== 6'h10 || capAddr[10] !== 6'h19 || capAcc[12] !== 16'd215) begin
            testsFailed++;
            $display("[TB] FAIL rmid_restart: got addr1=%h addr10=%h sum=%0d need 10 19 215", capAddr[1], capAddr[10], capAcc[12]);
        end
    endtask

`ifdef ACC_SEQ_PINGPONG_EN
    task automatic test_pingpong();
        $display("[TB] test_pingpong");
        iRsn = 1'b0;
        @(negedge iClk);
        iRsn = 1'b1;
        expBank = 1'b0;
        @(negedge iClk);
        capture_sequence(6'h00);
        for (int c = 1; c <= 10; c++) begin
            testsRun++;
            if (capAddr[c] !== 6'(c - 1) || capBank[c] !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL pp_first t%0d: got addr=%h bank=%b need %h 0", c, capAddr[c], capBank[c], 6'(c - 1));
            end
        end
        capture_sequence(6'h00);
        for (int c = 1; c <= 10; c++) begin
            testsRun++;
            if (capAddr[c] !== 6'(32 + c - 1) || capBank[c] !== 1'b1) begin
                testsFailed++;
                $display("[TB] FAIL pp_second t%0d: got addr=%h bank=%b need %h 1", c, capAddr[c], capBank[c], 6'(32 + c - 1));
            end
        end
    endtask
`endif

    initial begin
        fill_sram();
        @(negedge iClk);
        test_reset();
        test_basic();
        test_wrap();
        test_drop();
        test_saturation();
        test_back_to_back();
        test_reset_mid();
`ifdef ACC_SEQ_PINGPONG_EN
        test_pingpong();
`endif
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule : tb_acc_seq_ctrl
